// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
//   state_e        - loader FSM states
//   BYTES_PER_WORD - bytes packed into one instruction word
//   WORD_W         - instruction word width
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts bytes into a big-endian word and flags the byte that completes it.
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   clr_i          - restart the byte counter for a new load
//   shift_i        - accept byte_i this cycle
//   byte_i         - incoming byte
//   word_o         - packed word, first byte of the group in the top bits
//   word_full_o    - high while the last byte of a word is being shifted in
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = shift_i ? {word_q[WORD_W-9:0], byte_i} : word_q;
        cnt_d  = clr_i ? '0 : shift_i ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit big-endian words and writes them to
// instruction memory from address 0, holding the CPU in reset until a load succeeds.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   start_i, word_count_i - load request and number of words (latched in IDLE)
//   in_data_i, in_valid_i, in_ready_o - byte stream handshake
//   mem_we_o, mem_addr_o, mem_wdata_o - instruction memory write port
//   cpu_rst_o             - CPU reset, released after a successful load
//   busy_o, done_o, err_o - status: not idle, end-of-load pulse, checksum mismatch
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   word_count_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e LAST = CHECK;
`else
    localparam state_e LAST = DONE;
`endif

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d, idx_q, idx_d;
    logic            cpu_rst_q, cpu_rst_d, err_q, err_d;
    logic            clr, xfer, shift_en, word_full;

    assign in_ready_o = (state_q == RECV) || (state_q == CHECK);
    assign xfer       = in_valid_i && in_ready_o;
    assign shift_en   = xfer && (state_q == RECV);
    assign clr        = (state_q == IDLE) && start_i;

    word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr),
        .shift_i     (shift_en),
        .byte_i      (in_data_i),
        .word_o      (mem_wdata_o),
        .word_full_o (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign csum_d = clr ? 8'h00 : shift_en ? csum_q ^ in_data_i : csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) csum_q <= 8'h00;
        else       csum_q <= csum_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cpu_rst_d = cpu_rst_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (start_i) begin
                cnt_d     = word_count_i;
                idx_d     = '0;
                err_d     = 1'b0;
                cpu_rst_d = 1'b1;
                state_d   = (word_count_i == '0) ? DONE : RECV;
            end
            RECV: state_d = word_full ? WRITE : RECV;
            WRITE: begin
                // idx is one bit wider than the address so a full-depth load terminates
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == cnt_q) ? LAST : RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (xfer) begin
                err_d   = in_data_i != csum_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                // a failed checksum keeps the CPU parked until the next load
                cpu_rst_d = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
        end
    end

    assign mem_we_o   = state_q == WRITE;
    assign mem_addr_o = idx_q[ADDR_W-1:0];
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = state_q != IDLE;
    assign done_o     = state_q == DONE;
    assign err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench with a write-queue model of the loader.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, mem_we, cpu_rst, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    int  tests = 0, fails = 0, cyc = 0, last_we_cyc = 0, n_we = 0;
    bit  ready_seen = 1'b0;
    wr_t exp_q[$];
    wr_t e;
    logic [31:0] mem_seen [2**ADDR_W];
    logic [7:0]  t1[$] = '{8'h20, 8'h11, 8'h00, 8'h05, 8'h01, 8'h22, 8'h18, 8'h20};
    logic [7:0]  big[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .word_count_i (word_count),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .cpu_rst_o    (cpu_rst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // every write must match the next entry the model expects
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready) ready_seen = 1'b1;
            if (mem_we) begin
                n_we++;
                last_we_cyc = cyc;
                mem_seen[mem_addr] = mem_wdata;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0h data %h, required no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.a));
                    check("wr_data", 64'(mem_wdata), 64'(e.d));
                end
            end
        end
    end

    task automatic start_load(input int cnt);
        @(negedge clk);
        word_count = (ADDR_W+1)'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b[$], input bit gaps);
        int i = 0;
        int t = 0;
        while (i < b.size() && t < 4 * b.size() + 50) begin
            @(negedge clk);
            in_valid = gaps ? ((t % 2) == 0) : 1'b1;
            in_data = b[i];
            if (in_valid && in_ready) i++;
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bytes_accepted", 64'(i), 64'(b.size()));
    endtask

    task automatic wait_done(output int dc);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got done=0 after 100 cycles, required done=1");
        end
        dc = cyc;
    endtask

    // expected writes are word i = bytes 4i..4i+3, first byte most significant, at address i
    task automatic run_load(input int cnt, input logic [7:0] b[$], input bit gaps, input int poke);
        int  dc;
        wr_t w;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        b.push_back(x);
`endif
        for (int i = 0; i < cnt; i++) begin
            w.a = ADDR_W'(i);
            w.d = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            exp_q.push_back(w);
        end
        n_we = 0;
        start_load(cnt);
        check("ready_after_start", 64'(in_ready), 64'(1));
        check("cpu_rst_held", 64'(cpu_rst), 64'(1));
        if (poke > 0) begin
            feed(b[0:poke-1], gaps);
            @(negedge clk);
            word_count = (ADDR_W+1)'(1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("stray_start_ignored", 64'(in_ready), 64'(1));
            feed(b[poke:$], gaps);
        end else begin
            feed(b, gaps);
        end
        wait_done(dc);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("done_latency", 64'(dc - last_we_cyc), 64'(1));
`endif
        check("err_after_load", 64'(err), 64'(0));
        check("write_count", 64'(n_we), 64'(cnt));
        check("writes_pending", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        check("cpu_rst_release", 64'(cpu_rst), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) big.push_back(8'((i * 7) + 3));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_cpu_rst", 64'(cpu_rst), 64'(1));

        run_load(2, t1, 1'b0, 0);
        check("word0_literal", 64'(mem_seen[0]), 64'h20110005);
        check("word1_literal", 64'(mem_seen[1]), 64'h01221820);

        run_load(2, t1, 1'b1, 0);

        n_we = 0;
        ready_seen = 1'b0;
        start_load(0);
        check("zero_done", 64'(done), 64'(1));
        check("zero_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'(0));
        check("zero_cpu_rst", 64'(cpu_rst), 64'(0));
        repeat (3) @(negedge clk);
        check("zero_writes", 64'(n_we), 64'(0));
        check("zero_ready_seen", 64'(ready_seen), 64'(0));

        n_we = 0;
        e.a = '0;
        e.d = 32'h20110005;
        exp_q.push_back(e);
        start_load(2);
        feed(t1[0:5], 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        check("mid_rst_mem_we", 64'(mem_we), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_cpu_rst", 64'(cpu_rst), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_writes", 64'(n_we), 64'(1));
        check("mid_rst_pending", 64'(exp_q.size()), 64'(0));
        run_load(2, t1, 1'b0, 0);

        run_load(2, t1, 1'b0, 3);

        run_load(64, big, 1'b0, 0);
        check("full_depth_last", 64'(mem_seen[63]), 64'hE7EEF5FC);

`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load(1, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0, 0);
        check("csum_good_word", 64'(mem_seen[0]), 64'hAABBCCDD);
        begin
            int dc;
            e.a = '0;
            e.d = 32'hAABBCCDD;
            exp_q.push_back(e);
            start_load(1);
            feed('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01}, 1'b0);
            wait_done(dc);
            check("csum_bad_err", 64'(err), 64'(1));
            repeat (4) @(negedge clk);
            check("csum_bad_cpu_rst", 64'(cpu_rst), 64'(1));
            check("csum_bad_err_hold", 64'(err), 64'(1));
            start_load(0);
            check("csum_err_cleared", 64'(err), 64'(0));
            @(negedge clk);
            check("csum_cpu_rst_release", 64'(cpu_rst), 64'(0));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side counterpart of the CPU's instruction fetch path: receives a byte stream over a valid/ready handshake, packs it into 32-bit big-endian instruction words and writes them sequentially into instruction memory from address 0. Holds the CPU in reset (`cpu_rst`) while a load is in progress and releases it only after a successful load. Sits between a host byte source (UART/debug bridge) and the instruction memory write port.

## Interface
- `ADDR_W`, default 6: instruction memory word-address width (2^ADDR_W words).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to load, 0..2^ADDR_W; latched on accepted `start`.
- `in_data`  in  8  incoming byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte; transfer when `in_valid && in_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_rst`  out  1  reset to CPU; high while CPU must not run.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of load.
- `err`  out  1  checksum mismatch flag (constant 0 when checksum not compiled in).

## Operation
- Reset values: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `cpu_rst`=1 (CPU held until first successful load).
- IDLE: `in_ready`=0. On `start`: latch `word_count`, clear word index, byte index, `err`, checksum; drive `cpu_rst`=1. If count=0 go DONE, else RECV.
- RECV: `in_ready`=1. Each transfer shifts byte in: first byte -> bits 31:24, fourth -> bits 7:0. After the 4th byte go WRITE. `in_valid` gaps stall without loss.
- WRITE: `in_ready`=0, `mem_we`=1, `mem_addr`=word index, `mem_wdata`=packed word. Then increment word index; if it equals count go CHECK (macro on) or DONE, else RECV.
- CHECK (macro only): `in_ready`=1; accept one byte, compare with XOR of all data bytes; mismatch sets `err`. Go DONE.
- DONE: `done`=1 for one cycle, then IDLE. `cpu_rst` falls entering IDLE if `err`=0; stays 1 if `err`=1. `err` holds until next accepted `start`.
- `start` outside IDLE ignored. Count = 2^ADDR_W: last write at address 2^ADDR_W-1, index wrap never used for writing.
- `rst` mid-load: immediate return to reset values; partially packed word discarded, no write issued.

## Timing
- `start` sampled at edge N -> RECV from N; `in_ready` high in cycle after N.
- Back-to-back bytes: 4 accept cycles + 1 WRITE cycle = 5 cycles/word minimum.
- `mem_we` is registered; write occurs on the edge ending the WRITE cycle.
- `done` high the cycle after last WRITE (or after CHECK byte accepted); `cpu_rst` low the cycle after `done`.
- count=0: `done` high the cycle after `start` edge; no `mem_we`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CHECK state, trailing XOR byte required, `err` driven as above.
- Undefined: no CHECK state, no trailing byte, `err` tied 0, DONE directly after last WRITE.

## Structure
- Package `imem_loader_pkg`: state enum (IDLE, RECV, WRITE, CHECK, DONE), `BYTES_PER_WORD`=4, `WORD_W`=32.
- One sub-module `word_packer`: byte shift register + 2-bit byte counter, outputs packed word and `word_full`.

## Test plan
- Load 2 words, bytes 20 11 00 05, 01 22 18 20, no gaps -> writes addr0=0x20110005, addr1=0x01221820; `done` one cycle after second write; `cpu_rst` falls next cycle.
- Same stream with `in_valid` toggling every other cycle -> identical writes, no duplicated or lost bytes.
- `word_count`=0 -> no `mem_we`, `done` one cycle after `start`, `in_ready` never high.
- Assert `rst` after 6 bytes of a 2-word load -> only addr0 written, all outputs reset, `cpu_rst`=1; restart loads correctly.
- `start` pulsed during RECV -> ignored, count and indices unchanged.
- Macro on: 1 word 0xAABBCCDD + checksum 0x00 -> `err`=0, `cpu_rst` released; checksum 0x01 -> `err`=1, `cpu_rst` stays 1 until next `start`.
